// File: rtl/retro16_pkg.sv
// rtl/retro16_pkg.sv - shared constants for the retro16 ALU sequencer slice
package retro16_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 3;

  localparam logic [2:0] OP_SHIFT = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_OR    = 3'b110;
  localparam logic [2:0] OP_NOT   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

endpackage

// File: rtl/regfile8x16.sv
// rtl/regfile8x16.sv - register file, two operand read ports, one debug read port, r0 reads zero
module regfile8x16
  import retro16_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata2,
  input  logic [ADDR_WIDTH-1:0] dbg_raddr,
  output logic [DATA_WIDTH-1:0] dbg_rdata
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [NREGS];
  logic [DATA_WIDTH-1:0] mem_d [NREGS];

  // Writes to index 0 are dropped, so mem_q[0] stays at its reset value of zero.
  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != '0)) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata1    = (raddr1 == '0)    ? '0 : mem_q[raddr1];
  assign rdata2    = (raddr2 == '0)    ? '0 : mem_q[raddr2];
  assign dbg_rdata = (dbg_raddr == '0) ? '0 : mem_q[dbg_raddr];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issue/writeback FSM in front of the 16-bit ALU
module alu_sequencer
  import retro16_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic                  use_imm,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic                  busy,
  output logic                  done,
  output logic                  zero_flag,
  output logic                  neg_flag,
  output logic [DATA_WIDTH-1:0] alu_operand1,
  output logic [DATA_WIDTH-1:0] alu_operand2,
  output logic [2:0]            alu_operation,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [ADDR_WIDTH-1:0] dbg_raddr,
  output logic [DATA_WIDTH-1:0] dbg_rdata
);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic [2:0]            opn_q, opn_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  zero_q, zero_d;
  logic                  neg_q, neg_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic                  wb_we;

  assign wb_we = (state_q == ST_WB);

  regfile8x16 #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (wb_we),
    .waddr     (rd_q),
    .wdata     (res_q),
    .raddr1    (rs1),
    .rdata1    (rs1_data),
    .raddr2    (rs2),
    .rdata2    (rs2_data),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  // Operands and opcode hold outside of accept so the ALU sees stable inputs.
  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    opn_d   = opn_q;
    rd_d    = rd_q;
    res_d   = res_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op1_d   = rs1_data;
          op2_d   = use_imm ? imm : rs2_data;
          opn_d   = op;
          rd_d    = rd;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_result;
        state_d = ST_WB;
      end
      ST_WB: begin
        zero_d  = (res_q == '0);
        neg_d   = res_q[DATA_WIDTH-1];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      opn_q   <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opn_q   <= opn_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  assign busy          = (state_q == ST_EXEC) || (state_q == ST_WB);
  assign done          = done_q;
  assign zero_flag     = zero_q;
  assign neg_flag      = neg_q;
  assign alu_operand1  = op1_q;
  assign alu_operand2  = op2_q;
  assign alu_operation = opn_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized and directed bench for alu_sequencer against a timeline model
module tb_alu_sequencer;
  import retro16_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op, rd, rs1, rs2, dbg_raddr;
  logic        use_imm;
  logic [15:0] imm;
  logic        busy, done, zero_flag, neg_flag;
  logic [15:0] alu_operand1, alu_operand2, alu_result, dbg_rdata;
  logic [2:0]  alu_operation;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .use_imm(use_imm), .imm(imm), .busy(busy), .done(done), .zero_flag(zero_flag),
    .neg_flag(neg_flag), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_operation(alu_operation), .alu_result(alu_result), .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata)
  );

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o);
    logic [15:0] nb;
    nb = -b;
    case (o)
      OP_SHIFT: alu_f = b[15] ? (a >> nb[3:0]) : (a << b[3:0]);
      OP_ADD:   alu_f = a + b;
      OP_AND:   alu_f = a & b;
      OP_OR:    alu_f = a | b;
      OP_NOT:   alu_f = ~a;
      default:  alu_f = 16'h0000;
    endcase
  endfunction

  assign alu_result = alu_f(alu_operand1, alu_operand2, alu_operation);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: an accepted instruction is computed one cycle later and retired the cycle after.
  logic [15:0] m_reg [8];
  logic [15:0] m_op1, m_op2, m_res;
  logic [2:0]  m_op, m_rd;
  logic        m_z, m_n, m_done;
  int          m_phase;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
      m_op1 = 0; m_op2 = 0; m_op = 0; m_rd = 0; m_res = 0;
      m_z = 0; m_n = 0; m_done = 0; m_phase = 0;
    end else begin
      m_done = 0;
      if (m_phase == 2) begin
        if (m_rd != 0) m_reg[m_rd] = m_res;
        m_z = (m_res == 16'h0);
        m_n = m_res[15];
        m_done = 1;
        m_phase = 0;
      end else if (m_phase == 1) begin
        m_res = alu_f(m_op1, m_op2, m_op);
        m_phase = 2;
      end else if (start) begin
        m_op1 = m_reg[rs1];
        m_op2 = use_imm ? imm : m_reg[rs2];
        m_op = op;
        m_rd = rd;
        m_phase = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_phase != 0);
    chk("done", done, m_done);
    chk("zero_flag", zero_flag, m_z);
    chk("neg_flag", neg_flag, m_n);
    chk("alu_operand1", alu_operand1, m_op1);
    chk("alu_operand2", alu_operand2, m_op2);
    chk("alu_operation", alu_operation, m_op);
    chk("dbg_rdata", dbg_rdata, m_reg[dbg_raddr]);
  end

  bit dbg_rand = 0;
  always @(negedge clk) begin
    #1;
    if (dbg_rand) dbg_raddr = 3'($urandom_range(0, 7));
  end

  int          lat, busy_cycles;
  logic [15:0] acc_op1;

  task automatic issue(input logic [2:0] o, input logic [2:0] d, input logic [2:0] s1,
                       input logic [2:0] s2, input logic ui, input logic [15:0] im, input bit stray);
    op = o; rd = d; rs1 = s1; rs2 = s2; use_imm = ui; imm = im; start = 1'b1;
    lat = 0; busy_cycles = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1; lat++;
      if (busy) break;
    end
    start = 1'b0;
    acc_op1 = alu_operand1;
    if (busy) busy_cycles++;
    if (stray) begin
      rd = 3'd7; rs1 = 3'($urandom_range(0, 7)); op = OP_NOT; start = 1'b1;
      @(negedge clk); #1; lat++;
      if (busy) busy_cycles++;
      start = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1; lat++;
      if (done) break;
      if (busy) busy_cycles++;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: got done=%0d expected done=1", done);
    end
  endtask

  task automatic peek(input logic [2:0] idx, input logic [15:0] exp, input string name);
    dbg_raddr = idx;
    #1;
    chk(name, dbg_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 0; op = 0; rd = 0; rs1 = 0; rs2 = 0; use_imm = 0; imm = 0; dbg_raddr = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_op1", alu_operand1, 0);
    rst = 1'b0;
    @(negedge clk); #1;

    issue(OP_OR, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234, 0);
    chk("li_latency", lat, 3);
    chk("li_busy_cycles", busy_cycles, 2);
    peek(3'd1, 16'h1234, "li_r1");
    chk("li_zero", zero_flag, 0);
    chk("li_neg", neg_flag, 0);

    issue(OP_OR, 3'd2, 3'd0, 3'd0, 1'b1, 16'hEDCC, 0);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 0);
    peek(3'd3, 16'h0000, "add_r3");
    chk("add_zero", zero_flag, 1);
    chk("add_neg", neg_flag, 0);

    issue(OP_OR, 3'd1, 3'd0, 3'd0, 1'b1, 16'h8000, 0);
    issue(OP_SHIFT, 3'd4, 3'd1, 3'd0, 1'b1, 16'hFFFC, 0);
    peek(3'd4, 16'h0800, "shr_r4");
    issue(OP_SHIFT, 3'd5, 3'd1, 3'd0, 1'b1, 16'h0003, 0);
    peek(3'd5, 16'h0000, "shl_r5");
    chk("shl_zero", zero_flag, 1);

    issue(OP_NOT, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 0);
    peek(3'd0, 16'h0000, "r0_protect");
    chk("not_neg", neg_flag, 1);
    chk("not_zero", zero_flag, 0);
    issue(OP_NOT, 3'd6, 3'd0, 3'd0, 1'b0, 16'h0000, 0);
    peek(3'd6, 16'hFFFF, "not_r6");

    issue(OP_OR, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0055, 1);
    peek(3'd7, 16'h0000, "stray_r7");
    peek(3'd1, 16'h0055, "stray_r1");
    issue(OP_OR, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0000, 0);
    chk("b2b_latency", lat, 3);
    chk("b2b_operand1", acc_op1, 16'h0055);

    op = OP_OR; rd = 3'd2; rs1 = 3'd0; use_imm = 1'b1; imm = 16'hAAAA; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_zero", zero_flag, 0);
    chk("mid_rst_neg", neg_flag, 0);
    chk("mid_rst_op1", alu_operand1, 0);
    chk("mid_rst_op2", alu_operand2, 0);
    chk("mid_rst_opn", alu_operation, 0);
    for (int i = 0; i < 8; i++) peek(3'(i), 16'h0000, "mid_rst_reg");
    rst = 1'b0;
    @(negedge clk); #1;

    dbg_rand = 1;
    for (int t = 0; t < 200; t++) begin
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); #1;
      end
    end
    dbg_rand = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issue and writeback stage directly upstream of the 16-bit ALU; owns the 8-entry register file.
- Accepts one register-format or immediate-format instruction, reads the source registers, and drives the ALU operand and operation inputs.
- Captures the ALU result, writes it to the destination register, and updates the zero and negative flags.
- Three-state FSM; one instruction in flight at a time.

Parameters:
- DATA_WIDTH, 16, datapath width. Fixed at 16 to match the ALU; other values unsupported.
- ADDR_WIDTH, 3, register index width (8 registers).

Ports:
- clk  input  1  system clock. All state changes on its rising edge.
- rst  input  1  synchronous active-high reset, sampled on rising clk.
- start  input  1  instruction request. Sampled only in IDLE.
- op  input  3  ALU operation code, forwarded verbatim.
- rd  input  3  destination register index.
- rs1  input  3  source register for operand1.
- rs2  input  3  source register for operand2 (ignored when use_imm=1).
- use_imm  input  1  1: operand2 = imm; 0: operand2 = reg[rs2].
- imm  input  16  immediate operand.
- busy  output  1  high in EXEC and WB.
- done  output  1  one-cycle pulse after writeback.
- zero_flag  output  1  last written result == 0.
- neg_flag  output  1  bit 15 of last written result.
- alu_operand1  output  16  to ALU operand1.
- alu_operand2  output  16  to ALU operand2.
- alu_operation  output  3  to ALU operation.
- alu_result  input  16  from ALU result (combinational, valid in the same cycle).
- dbg_raddr  input  3  debug register read index.
- dbg_rdata  output  16  combinational reg[dbg_raddr].

Behaviour:
- Reset: state=IDLE, all 8 registers=0, busy=0, done=0, zero_flag=0, neg_flag=0, alu_operand1/2=0, alu_operation=0, result latch=0. Reset mid-instruction aborts with no register write.
- Register 0 is hardwired to zero: reads return 0 and writes are discarded. Flags still update on an rd=0 write.
- Register file reads are combinational, so dbg_rdata is combinational.
- FSM states: IDLE, EXEC, WB.
- IDLE, start=1 (edge E0):
  - alu_operand1 <= reg[rs1].
  - alu_operand2 <= use_imm ? imm : reg[rs2].
  - alu_operation <= op.
  - rd latched; next state EXEC.
- IDLE, start=0: outputs hold; stay in IDLE.
- EXEC (one cycle): ALU inputs stable. At edge E1, result latch <= alu_result; next state WB.
- WB (one cycle): at edge E2:
  - reg[rd] <= result latch (unless rd=0).
  - zero_flag <= (latch==0).
  - neg_flag <= latch[15].
  - done <= 1; next state IDLE.
- done is high for exactly the cycle after E2, and cleared at the following edge unless another WB completes.
- Latency: start accepted at E0 gives done high in cycle E2..E3, i.e. 3 cycles. Throughput is one instruction per 3 cycles.
- start while busy=1 is ignored, with no queueing. The requester must hold start until it observes busy go high.
- start in the same cycle done=1 (state IDLE) is accepted. The register read sees the just-written value (write at E2 precedes the read at E3). No forwarding is required.
- ALU inputs hold their last values in IDLE and WB. They are not zeroed.
- Opcodes are passed through unchecked:
  - 001/010/011 yield ALU result 0 and are written normally.
  - 000 is a shift: operand2 negative means right shift by the negated magnitude, low 4 bits used.
- rs1==rd and rs2==rd are legal; the sources are read at E0, before the write.

Decomposition:
- Shared package retro16_pkg:
  - ALU opcode constants: OP_SHIFT=3'b000, OP_ADD=3'b100, OP_AND=3'b101, OP_OR=3'b110, OP_NOT=3'b111.
  - Sequencer state encoding: IDLE=2'd0, EXEC=2'd1, WB=2'd2.
  - DATA_WIDTH/ADDR_WIDTH defaults.
- One sub-module, regfile8x16:
  - Two combinational read ports plus one debug read port.
  - One synchronous write port.
  - Synchronous reset; r0 hardwired zero.
- The FSM and operand muxing stay in alu_sequencer.

Test Plan:
- Load immediate: start, op=110, rs1=0, use_imm=1, imm=0x1234, rd=1. Required: busy high 2 cycles, done pulses 3 cycles after accept, dbg r1=0x1234, zero=0, neg=0.
- Add: with r1=0x1234 and r2=0xEDCC loaded, run op=100, rd=3, rs1=1, rs2=2. Required: r3=0x0000, zero_flag=1, neg_flag=0.
- Signed shift: r1=0x8000, op=000, use_imm=1, imm=0xFFFC, rd=4. Required: r4=0x0800. Then imm=0x0003 on r1 with rd=5 gives r5=0x0000 and zero=1.
- r0 protection and NOT: op=111, rs1=0, rd=0. Required: r0 still reads 0, neg_flag=1, zero_flag=0. Then op=111 with rd=6 gives r6=0xFFFF.
- Busy rejection and back-to-back: pulse start again during EXEC with rd=7. Required: ignored, r7 unchanged. Then start held in the done cycle with rs1 = the just-written rd: accepted, and the operand equals the new value.
- Reset mid-op: assert rst during WB of a write to r2=0xAAAA. Required: next cycle all regs 0, state IDLE, busy=0, done=0, flags 0, alu_* outputs 0.
